// File: rtl/image_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : image_rom_pkg
// Description : Shared types and defaults for the image ROM read arbiter.
//               Holds the requester ID encoding, the response tag that
//               travels with each ROM read, and the default ROM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package image_rom_pkg;

    localparam int IMG_LENGTH = 65536;   // 256x256 image, one pixel per word
    localparam int PIX_WIDTH  = 8;
    localparam int ADDR_W     = 32;

    typedef enum logic {
        REQ_DISP = 1'b0,                 // VGA display fetch, latency critical
        REQ_PROC = 1'b1                  // image-processing engine, bulk
    } req_id_t;

    // Captured on every grant; describes the ROM word arriving next cycle.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    err;
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/image_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : image_rom_arbiter_if
// Description : Request/response bus between the two ROM readers, the
//               arbiter and the ROM read port.
//               reqX_valid/addr/ready : request handshake per requester
//               rspX_valid/data/err   : one-cycle response per requester
//               rom_addr / rom_rd     : ROM read port (registered read)
//               modport slave  : arbiter side
//               modport master : requesters / ROM side
// Revision    : 1.0 - initial release
// ============================================================================
interface image_rom_arbiter_if
    import image_rom_pkg::*;
#(
    parameter int WIDTH = PIX_WIDTH
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [WIDTH-1:0]  rsp0_data;
    logic              rsp0_err;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [WIDTH-1:0]  rsp1_data;
    logic              rsp1_err;

    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_rd;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, rom_rd,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        output rom_addr
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, rom_rd,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        input  rom_addr
    );

endinterface
`default_nettype wire

// File: rtl/image_rom_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : starve_counter
// Description : Saturating up-counter with clear. Counts how many times a
//               low-priority requester has lost arbitration in a row.
//               clk      : clock
//               rst      : synchronous active-high reset
//               i_inc    : increment (saturates at STARVE_MAX)
//               i_clr    : clear to 0 (wins over i_inc)
//               o_at_max : count equals STARVE_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module starve_counter #(
    parameter  int STARVE_MAX = 4,
    localparam int C_CNT_W    = $clog2(STARVE_MAX + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_at_max
);

    localparam logic [C_CNT_W-1:0] c_MAX = C_CNT_W'(STARVE_MAX);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/image_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : image_rom_arbiter
// Description : Two-port read arbiter in front of the image ROM's single
//               registered read port. Grants one request per cycle
//               (display first, processing engine after STARVE_MAX lost
//               contentions), blocks out-of-range addresses and routes the
//               ROM word back to the issuer one cycle later.
//               clk : clock
//               rst : synchronous active-high reset
//               bus : image_rom_arbiter_if.slave (requests, responses, ROM)
// Revision    : 1.0 - initial release
// ============================================================================
module image_rom_arbiter
    import image_rom_pkg::*;
#(
    parameter int WIDTH      = PIX_WIDTH,
    parameter int LENGTH     = IMG_LENGTH,
    parameter int STARVE_MAX = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    image_rom_arbiter_if.slave   bus
);

    localparam logic [ADDR_W-1:0] c_LENGTH = ADDR_W'(LENGTH);

    logic              w_at_max;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_in_range;
    logic              w_rsp0;
    logic              w_rsp1;
    rsp_tag_t          r_tag;

    // Ready is the grant itself: it never looks at response state, so a
    // requester can issue every cycle. Reset masks everything.
    always_comb begin
        w_grant1   = !rst && bus.req1_valid && (!bus.req0_valid || w_at_max);
        w_grant0   = !rst && bus.req0_valid && !w_grant1;
        w_any      = w_grant0 || w_grant1;
        w_gnt_addr = w_grant1 ? bus.req1_addr : bus.req0_addr;
        // Full-width unsigned compare; the ROM never sees a wrapped address.
        w_in_range = (w_gnt_addr < c_LENGTH);
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rom_addr   = (w_any && w_in_range) ? w_gnt_addr : '0;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_grant0 && bus.req1_valid),
        .i_clr    (w_grant1),
        .o_at_max (w_at_max)
    );

    // Tag follows the ROM's own one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '{valid: 1'b0, id: REQ_DISP, err: 1'b0};
        end else begin
            r_tag.valid <= w_any;
            r_tag.id    <= w_grant1 ? REQ_PROC : REQ_DISP;
            r_tag.err   <= w_any && !w_in_range;
        end
    end

    // Reset gating also swallows the response to a grant made just before
    // reset rose.
    assign w_rsp0 = !rst && r_tag.valid && (r_tag.id == REQ_DISP);
    assign w_rsp1 = !rst && r_tag.valid && (r_tag.id == REQ_PROC);

    assign bus.rsp0_valid = w_rsp0;
    assign bus.rsp0_err   = w_rsp0 && r_tag.err;
    assign bus.rsp0_data  = (w_rsp0 && !r_tag.err) ? bus.rom_rd : '0;

    assign bus.rsp1_valid = w_rsp1;
    assign bus.rsp1_err   = w_rsp1 && r_tag.err;
    assign bus.rsp1_data  = (w_rsp1 && !r_tag.err) ? bus.rom_rd : '0;

endmodule
`default_nettype wire

// File: tb/tb_image_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_rom_arbiter
// Description : Directed self-checking bench for image_rom_arbiter with a
//               behavioural registered-read ROM and a small reference model
//               for a randomised run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_rom_arbiter;
    import image_rom_pkg::*;

    localparam int c_SMAX = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    image_rom_arbiter_if #(.WIDTH(8)) bus ();

    image_rom_arbiter #(
        .WIDTH      (8),
        .LENGTH     (65536),
        .STARVE_MAX (c_SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM contents: word 0x10 holds 0xA5.
    function automatic logic [7:0] rom_f(input logic [31:0] a);
        return 8'((a[7:0] ^ a[15:8]) + 8'h95);
    endfunction

    always @(posedge clk) bus.rom_rd <= rom_f(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0,
                         input logic v1, input logic [31:0] a1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
    endtask

    int           exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int           exp_c [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    logic         sv0, sv1, eg0, eg1, p0, p1, perr;
    logic [31:0]  sa0, sa1, ga;
    logic [7:0]   pdata;
    int           mcnt, wait1, r;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 32'h20);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp0_data", bus.rsp0_data, 0);
        chk("rst_rsp1_err", bus.rsp1_err, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_cnt", dut.u_starve.r_count, 0);

        // ---------------- single requester, first cycle after reset ----
        cyc();
        rst = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 32'h0);
        @(negedge clk);
        chk("single_ready0", bus.req0_ready, 1);
        chk("single_ready1", bus.req1_ready, 0);
        chk("single_rom_addr", bus.rom_addr, 32'h10);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("single_rsp0_valid", bus.rsp0_valid, 1);
        chk("single_rsp0_data", bus.rsp0_data, 8'hA5);
        chk("single_rsp0_err", bus.rsp0_err, 0);
        chk("single_rsp1_valid", bus.rsp1_valid, 0);

        // ---------------- sustained contention ----------------
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(1'b1, 32'h40 + i, 1'b1, 32'h80 + i);
            @(negedge clk);
            chk("cont_cnt", dut.u_starve.r_count, exp_c[i]);
            chk("cont_ready1", bus.req1_ready, exp_g[i]);
            chk("cont_ready0", bus.req0_ready, 1 - exp_g[i]);
            if (i > 0) begin
                if (exp_g[i-1] == 0) begin
                    chk("cont_rsp0_valid", bus.rsp0_valid, 1);
                    chk("cont_rsp0_data", bus.rsp0_data, rom_f(32'h40 + i - 1));
                    chk("cont_rsp1_valid", bus.rsp1_valid, 0);
                end else begin
                    chk("cont_rsp1_valid", bus.rsp1_valid, 1);
                    chk("cont_rsp1_data", bus.rsp1_data, rom_f(32'h80 + i - 1));
                    chk("cont_rsp0_valid", bus.rsp0_valid, 0);
                end
            end
        end
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("cont_last_rsp1_valid", bus.rsp1_valid, 1);
        chk("cont_last_rsp1_data", bus.rsp1_data, 8'h1E);
        chk("cont_cnt_after", dut.u_starve.r_count, 0);

        // ---------------- out of range ----------------
        cyc();
        drive(1'b0, 32'h0, 1'b1, 32'h0001_0000);
        @(negedge clk);
        chk("oor_ready1", bus.req1_ready, 1);
        chk("oor_rom_addr", bus.rom_addr, 0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_FFFF);
        @(negedge clk);
        chk("oor_rsp1_valid", bus.rsp1_valid, 1);
        chk("oor_rsp1_err", bus.rsp1_err, 1);
        chk("oor_rsp1_data", bus.rsp1_data, 0);
        chk("oor_rsp0_valid", bus.rsp0_valid, 0);
        chk("edge_rom_addr", bus.rom_addr, 32'hFFFF);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("edge_rsp1_valid", bus.rsp1_valid, 1);
        chk("edge_rsp1_err", bus.rsp1_err, 0);
        chk("edge_rsp1_data", bus.rsp1_data, 8'h95);

        // ---------------- interleaved 0,1,0 ----------------
        cyc();
        drive(1'b1, 32'h100, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 32'h200);
        @(negedge clk);
        chk("il_a_rsp0_valid", bus.rsp0_valid, 1);
        chk("il_a_rsp0_data", bus.rsp0_data, 8'h96);
        chk("il_a_rsp1_valid", bus.rsp1_valid, 0);
        cyc();
        drive(1'b1, 32'h300, 1'b0, 32'h0);
        @(negedge clk);
        chk("il_b_rsp1_valid", bus.rsp1_valid, 1);
        chk("il_b_rsp1_data", bus.rsp1_data, 8'h97);
        chk("il_b_rsp0_valid", bus.rsp0_valid, 0);
        chk("il_b_rsp0_data", bus.rsp0_data, 0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("il_c_rsp0_valid", bus.rsp0_valid, 1);
        chk("il_c_rsp0_data", bus.rsp0_data, 8'h98);
        chk("il_c_rsp1_valid", bus.rsp1_valid, 0);

        // ---------------- reset mid-operation ----------------
        cyc();
        drive(1'b1, 32'h11, 1'b1, 32'h22);
        @(negedge clk);
        chk("rm_cnt0", dut.u_starve.r_count, 0);
        cyc();
        drive(1'b1, 32'h10, 1'b0, 32'h0);
        @(negedge clk);
        chk("rm_cnt1", dut.u_starve.r_count, 1);
        chk("rm_ready0", bus.req0_ready, 1);
        cyc();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rm_rsp0_valid", bus.rsp0_valid, 0);
        chk("rm_rsp0_data", bus.rsp0_data, 0);
        chk("rm_rom_addr", bus.rom_addr, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_post_rsp0_valid", bus.rsp0_valid, 0);
        chk("rm_post_rsp1_valid", bus.rsp1_valid, 0);
        chk("rm_post_ready0", bus.req0_ready, 0);
        chk("rm_post_rom_addr", bus.rom_addr, 0);
        chk("rm_post_cnt", dut.u_starve.r_count, 0);

        // ---------------- randomised run against a model ----------------
        p0 = 1'b0; p1 = 1'b0; perr = 1'b0; pdata = 8'h0;
        mcnt = 0; wait1 = 0;
        for (int k = 0; k < 2000; k++) begin
            cyc();
            sv0 = 1'($urandom_range(0, 1));
            sv1 = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            sa0 = (r == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 65535));
            r = $urandom_range(0, 9);
            sa1 = (r == 0) ? 32'h0001_0000 + 32'($urandom_range(0, 255))
                           : 32'($urandom_range(0, 65535));
            drive(sv0, sa0, sv1, sa1);
            @(negedge clk);
            eg1 = sv1 && (!sv0 || mcnt == c_SMAX);
            eg0 = sv0 && !eg1;
            ga  = eg1 ? sa1 : sa0;
            chk("rnd_ready0", bus.req0_ready, eg0);
            chk("rnd_ready1", bus.req1_ready, eg1);
            chk("rnd_rom_addr", bus.rom_addr,
                ((eg0 || eg1) && ga < 32'h1_0000) ? ga : 32'h0);
            chk("rnd_rsp0_valid", bus.rsp0_valid, p0);
            chk("rnd_rsp1_valid", bus.rsp1_valid, p1);
            if (p0) begin
                chk("rnd_rsp0_data", bus.rsp0_data, pdata);
                chk("rnd_rsp0_err", bus.rsp0_err, perr);
            end
            if (p1) begin
                chk("rnd_rsp1_data", bus.rsp1_data, pdata);
                chk("rnd_rsp1_err", bus.rsp1_err, perr);
            end
            p0    = eg0;
            p1    = eg1;
            perr  = ga >= 32'h1_0000;
            pdata = perr ? 8'h0 : rom_f(ga);
            if (eg1) mcnt = 0;
            else if (eg0 && sv1 && mcnt < c_SMAX) mcnt++;
            if (sv1 && !eg1) wait1++;
            else wait1 = 0;
            chk("rnd_starve_wait", (wait1 <= c_SMAX) ? 1 : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
